mem_wb_pipe: RTL and testbench

//   Parametrised MEM->WB stage buffer: replaces the fixed single-register MEM/WB latch with a

---
 rtl/mem_wb_pipe.sv | 85 ++++++++
 tb/tb_mem_wb_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM->WB elastic buffer: DEPTH-entry FIFO of NCH write channels between LSU and WB.
// Retire pulses one cycle after each pop; flush drops everything synchronously.
module mem_wb_pipe #(
  parameter int NCH   = 2,
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                      ck_i,
  input  logic                      rs_n_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NCH-1:0]            ch_we_i,
  input  logic [NCH*AW-1:0]         ch_wa_i,
  input  logic [NCH*DW-1:0]         ch_wd_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [NCH-1:0]            ch_we_o,
  output logic [NCH*AW-1:0]         ch_wa_o,
  output logic [NCH*DW-1:0]         ch_wd_o,
  output logic                      instret_incr_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              instret;
  logic              push;
  logic              pop;

  logic [NCH-1:0]    we_mem [DEPTH];
  logic [NCH*AW-1:0] wa_mem [DEPTH];
  logic [NCH*DW-1:0] wd_mem [DEPTH];

  // Handshake flags come from registered count only.
  assign in_ready_o  = count < CW'(DEPTH);
  assign out_valid_o = count != '0;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      instret <= 1'b0;
    end else if (flush_i) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      instret <= 1'b0;
    end else begin
      instret <= pop;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: every read is gated by out_valid_o.
  always_ff @(posedge ck_i) begin
    if (push) begin
      we_mem[wr_ptr] <= ch_we_i;
      wa_mem[wr_ptr] <= ch_wa_i;
      wd_mem[wr_ptr] <= ch_wd_i;
    end
  end

  assign ch_we_o        = out_valid_o ? we_mem[rd_ptr] : '0;
  assign ch_wa_o        = out_valid_o ? wa_mem[rd_ptr] : '0;
  assign ch_wd_o        = out_valid_o ? wd_mem[rd_ptr] : '0;
  assign instret_incr_o = instret;
  assign count_o        = count;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed scenarios plus a randomized run
// against a queue-based model of the buffer.
module tb_mem_wb_pipe;

  localparam int NCH   = 2;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic              ck_i = 1'b0;
  logic              rs_n_i;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [NCH-1:0]    ch_we_i;
  logic [NCH*AW-1:0] ch_wa_i;
  logic [NCH*DW-1:0] ch_wd_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [NCH-1:0]    ch_we_o;
  logic [NCH*AW-1:0] ch_wa_o;
  logic [NCH*DW-1:0] ch_wd_o;
  logic              instret_incr_o;
  logic [$clog2(DEPTH):0] count_o;

  mem_wb_pipe #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .ck_i(ck_i), .rs_n_i(rs_n_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ch_we_i(ch_we_i), .ch_wa_i(ch_wa_i), .ch_wd_i(ch_wd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ch_we_o(ch_we_o), .ch_wa_o(ch_wa_o), .ch_wd_o(ch_wd_o),
    .instret_incr_o(instret_incr_o), .count_o(count_o)
  );

  always #5 ck_i = ~ck_i;

  typedef struct packed {
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] wa;
    logic [NCH*DW-1:0] wd;
  } ent_t;

  ent_t q[$];
  logic exp_ir;
  logic last_push;
  int   total;
  int   bad;

  function automatic ent_t rnd_ent();
    ent_t e;
    logic [63:0] r;
    r = {$urandom, $urandom};
    e.we = r[NCH-1:0];
    e.wa = r[NCH*AW-1:0];
    r = {$urandom, $urandom};
    e.wd = r[NCH*DW-1:0];
    return e;
  endfunction

  function automatic ent_t exp_head();
    ent_t z;
    z = '0;
    if (q.size() != 0) z = q[0];
    return z;
  endfunction

  task automatic drive(input logic v, input ent_t e);
    in_valid_i = v;
    ch_we_i    = e.we;
    ch_wa_i    = e.wa;
    ch_wd_i    = e.wd;
  endtask

  // One clock: model decides push/pop from the rules, then retires/accepts.
  task automatic tick();
    bit   psh;
    bit   pp;
    ent_t cur;
    psh = in_valid_i && !flush_i && (q.size() < DEPTH);
    pp  = (q.size() != 0) && out_ready_i && !flush_i;
    cur = '{we: ch_we_i, wa: ch_wa_i, wd: ch_wd_i};
    @(posedge ck_i);
    #1;
    last_push = psh;
    if (flush_i) begin
      q.delete();
      exp_ir = 1'b0;
    end else begin
      exp_ir = pp;
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(cur);
    end
  endtask

  task automatic test_reset();
    rs_n_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, '0);
    #12;
    q.delete();
    exp_ir = 1'b0;
    total++;
    if (count_o !== '0) begin
      bad++; $display("FAIL reset_count got=%0d exp=0", count_o);
    end
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_hs got=%b%b exp=10", in_ready_o, out_valid_o);
    end
    total++;
    if (ch_we_o !== '0 || ch_wa_o !== '0 || ch_wd_o !== '0 || instret_incr_o !== 1'b0) begin
      bad++; $display("FAIL reset_out we=%b wa=%h wd=%h ir=%b exp=0", ch_we_o, ch_wa_o, ch_wd_o, instret_incr_o);
    end
    @(negedge ck_i);
    rs_n_i = 1'b1;
  endtask

  task automatic test_single();
    ent_t e;
    e = '0;
    e.we = 2'b01;
    e.wa[AW-1:0] = 12'd5;
    e.wd[DW-1:0] = 32'hDEADBEEF;
    out_ready_i = 1'b1;
    drive(1'b1, e);
    tick();
    drive(1'b0, '0);
    total++;
    if (out_valid_o !== 1'b1 || ch_we_o !== 2'b01 || ch_wa_o[AW-1:0] !== 12'd5
        || ch_wd_o[DW-1:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_out v=%b we=%b wa=%h wd=%h exp=1 01 5 deadbeef", out_valid_o, ch_we_o, ch_wa_o, ch_wd_o);
    end
    tick();
    total++;
    if (instret_incr_o !== 1'b1 || count_o !== '0) begin
      bad++; $display("FAIL single_retire ir=%b cnt=%0d exp=1 0", instret_incr_o, count_o);
    end
  endtask

  task automatic test_backpressure();
    ent_t e1, e2, e3;
    int pulses;
    e1 = rnd_ent(); e2 = rnd_ent(); e3 = rnd_ent();
    pulses = 0;
    out_ready_i = 1'b0;
    drive(1'b1, e1);
    tick();
    total++;
    if (in_ready_o !== 1'b1 || count_o !== 2'd1) begin
      bad++; $display("FAIL bp_first rdy=%b cnt=%0d exp=1 1", in_ready_o, count_o);
    end
    drive(1'b1, e2);
    tick();
    total++;
    if (in_ready_o !== 1'b0 || count_o !== 2'd2) begin
      bad++; $display("FAIL bp_full rdy=%b cnt=%0d exp=0 2", in_ready_o, count_o);
    end
    drive(1'b1, e3);
    tick();
    total++;
    if (count_o !== 2'd2 || ch_wd_o !== e1.wd) begin
      bad++; $display("FAIL bp_third cnt=%0d wd=%h exp=2 %h", count_o, ch_wd_o, e1.wd);
    end
    drive(1'b0, '0);
    out_ready_i = 1'b1;
    tick();
    if (instret_incr_o === 1'b1) pulses++;
    total++;
    if (ch_wd_o !== e2.wd || ch_wa_o !== e2.wa || ch_we_o !== e2.we) begin
      bad++; $display("FAIL bp_order wd=%h exp=%h", ch_wd_o, e2.wd);
    end
    tick();
    if (instret_incr_o === 1'b1) pulses++;
    total++;
    if (pulses != 2 || count_o !== '0) begin
      bad++; $display("FAIL bp_retire pulses=%0d cnt=%0d exp=2 0", pulses, count_o);
    end
  endtask

  task automatic test_stream();
    ent_t sent[16];
    int pulses;
    int errs;
    pulses = 0;
    errs = 0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sent[i] = rnd_ent();
      drive(1'b1, sent[i]);
      tick();
      if (instret_incr_o === 1'b1) pulses++;
      total++;
      if (count_o !== 2'd1 || out_valid_o !== 1'b1 || ch_wd_o !== sent[i].wd
          || in_ready_o !== 1'b1) begin
        errs++;
        bad++; $display("FAIL stream_%0d cnt=%0d wd=%h exp=1 %h", i, count_o, ch_wd_o, sent[i].wd);
      end
    end
    drive(1'b0, '0);
    tick();
    if (instret_incr_o === 1'b1) pulses++;
    total++;
    if (pulses != 16 || count_o !== '0) begin
      bad++; $display("FAIL stream_pulses got=%0d cnt=%0d exp=16 0", pulses, count_o);
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    drive(1'b1, rnd_ent());
    tick();
    drive(1'b1, rnd_ent());
    tick();
    total++;
    if (count_o !== 2'd2) begin
      bad++; $display("FAIL flush_pre cnt=%0d exp=2", count_o);
    end
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, rnd_ent());
    tick();
    flush_i = 1'b0;
    drive(1'b0, '0);
    total++;
    if (count_o !== '0 || out_valid_o !== 1'b0 || ch_we_o !== '0 || instret_incr_o !== 1'b0) begin
      bad++; $display("FAIL flush_now cnt=%0d v=%b we=%b ir=%b exp=0 0 0 0", count_o, out_valid_o, ch_we_o, instret_incr_o);
    end
    tick();
    total++;
    if (out_valid_o !== 1'b0 || instret_incr_o !== 1'b0) begin
      bad++; $display("FAIL flush_after v=%b ir=%b exp=0 0", out_valid_o, instret_incr_o);
    end
  endtask

  task automatic test_zero_we();
    ent_t e;
    e = rnd_ent();
    e.we = '0;
    out_ready_i = 1'b1;
    drive(1'b1, e);
    tick();
    drive(1'b0, '0);
    total++;
    if (out_valid_o !== 1'b1 || ch_we_o !== '0 || ch_wd_o !== e.wd) begin
      bad++; $display("FAIL zwe_out v=%b we=%b wd=%h exp=1 0 %h", out_valid_o, ch_we_o, ch_wd_o, e.wd);
    end
    tick();
    total++;
    if (instret_incr_o !== 1'b1 || count_o !== '0) begin
      bad++; $display("FAIL zwe_retire ir=%b cnt=%0d exp=1 0", instret_incr_o, count_o);
    end
  endtask

  task automatic test_async_reset();
    ent_t e;
    out_ready_i = 1'b0;
    drive(1'b1, rnd_ent());
    tick();
    drive(1'b1, rnd_ent());
    tick();
    drive(1'b0, '0);
    total++;
    if (count_o !== 2'd2) begin
      bad++; $display("FAIL arst_pre cnt=%0d exp=2", count_o);
    end
    #2;
    rs_n_i = 1'b0;
    #1;
    q.delete();
    exp_ir = 1'b0;
    total++;
    if (count_o !== '0 || out_valid_o !== 1'b0 || ch_we_o !== '0 || ch_wd_o !== '0
        || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL arst_now cnt=%0d v=%b we=%b wd=%h rdy=%b exp=0 0 0 0 1", count_o, out_valid_o, ch_we_o, ch_wd_o, in_ready_o);
    end
    #4;
    rs_n_i = 1'b1;
    e = rnd_ent();
    out_ready_i = 1'b1;
    drive(1'b1, e);
    tick();
    drive(1'b0, '0);
    total++;
    if (out_valid_o !== 1'b1 || ch_wd_o !== e.wd || ch_wa_o !== e.wa || ch_we_o !== e.we) begin
      bad++; $display("FAIL arst_post v=%b wd=%h exp=1 %h", out_valid_o, ch_wd_o, e.wd);
    end
    tick();
    total++;
    if (instret_incr_o !== 1'b1) begin
      bad++; $display("FAIL arst_retire ir=%b exp=1", instret_incr_o);
    end
  endtask

  task automatic test_random();
    ent_t cur;
    ent_t h;
    bit   hold;
    hold = 1'b0;
    cur = rnd_ent();
    for (int i = 0; i < 400; i++) begin
      if (!hold) cur = rnd_ent();
      drive(($urandom_range(0, 9) < 7), cur);
      out_ready_i = ($urandom_range(0, 9) < 5);
      flush_i = ($urandom_range(0, 29) == 0);
      tick();
      hold = in_valid_i && !last_push && !flush_i;
      flush_i = 1'b0;
      h = exp_head();
      total++;
      if (int'(count_o) != q.size() || out_valid_o !== (q.size() != 0)
          || in_ready_o !== (q.size() < DEPTH) || instret_incr_o !== exp_ir) begin
        bad++; $display("FAIL rnd_ctl_%0d cnt=%0d v=%b r=%b ir=%b exp=%0d %b", i, count_o, out_valid_o, in_ready_o, instret_incr_o, q.size(), exp_ir);
      end
      total++;
      if (ch_we_o !== h.we || ch_wa_o !== h.wa || ch_wd_o !== h.wd) begin
        bad++; $display("FAIL rnd_data_%0d we=%b wa=%h wd=%h exp=%b %h %h", i, ch_we_o, ch_wa_o, ch_wd_o, h.we, h.wa, h.wd);
      end
    end
    drive(1'b0, '0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_push = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_zero_we();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
